// File: rtl/vp_pkg.sv
// Shared types and confidence update rule for the value-predictor feedback path.
package vp_pkg;

    localparam int VP_CONF_WIDTH = 8;

    typedef struct packed {
        logic [31:1]            pc;
        logic [31:0]            value;
        logic [VP_CONF_WIDTH:0] conf;
    } vp_upd_t;

    // Width-agnostic saturating increment; callers widen to 32 bits and truncate back.
    function automatic logic [31:0] vp_conf_next(input logic [31:0] conf,
                                                 input logic        mispredict,
                                                 input logic [31:0] conf_max);
        if (mispredict)
            return '0;
        if (conf >= conf_max)
            return conf_max;
        return conf + 32'd1;
    endfunction

endpackage

// File: rtl/vp_fb_fifo.sv
// Two-write / one-read FIFO with flush; slot 0 is written before slot 1 when both push.
module vp_fb_fifo #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [1:0]                 push,
    input  logic [P_WIDTH-1:0]         wr_data0,
    input  logic [P_WIDTH-1:0]         wr_data1,
    input  logic                       pop,
    output logic [P_WIDTH-1:0]         rd_data,
    output logic [$clog2(P_DEPTH):0]   count
);

    localparam int AW = $clog2(P_DEPTH);
    localparam int CW = AW + 1;

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr1;
    logic [1:0]         wr_ok;
    logic [CW-1:0]      n_push;
    logic               do_pop;

    assign wr_ok   = push & {2{~flush}};
    assign wr_ptr1 = wr_ok[0] ? wr_ptr + AW'(1) : wr_ptr;
    assign n_push  = CW'(wr_ok[0]) + CW'(wr_ok[1]);
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (wr_ok[0])
            mem[wr_ptr] <= wr_data0;
        if (wr_ok[1])
            mem[wr_ptr1] <= wr_data1;
    end

    // A flush drops any same-cycle pop and realigns the read side to the write side.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + n_push - CW'(do_pop);
        end
    end

    // Stale storage never leaks out: an empty FIFO presents zeros.
    assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/vp_fb_scheduler.sv
// Serializes 2-wide execute feedback into single-port predictor table updates.
// Optional macro VP_FB_MERGE_EN: same-PC slot pairs collapse into the younger slot.
module vp_fb_scheduler
    import vp_pkg::*;
#(
    parameter int P_CONF_WIDTH = 8,
    parameter int P_FIFO_DEPTH = 8,
    parameter int P_DROP_W     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [1:0][31:1]             fb_pc_i,
    input  logic [1:0][31:0]             fb_actual_i,
    input  logic [1:0]                   fb_mispredict_i,
    input  logic [1:0][P_CONF_WIDTH:0]   fb_conf_i,
    input  logic [1:0]                   fb_valid_i,
    output logic                         fb_ready_o,
    output logic [31:1]                  upd_pc_o,
    output logic [31:0]                  upd_value_o,
    output logic [P_CONF_WIDTH:0]        upd_conf_o,
    output logic                         upd_valid_o,
    input  logic                         upd_ready_i,
    output logic [P_DROP_W-1:0]          drop_cnt_o
);

    localparam int CW = $clog2(P_FIFO_DEPTH) + 1;
    localparam int FW = P_CONF_WIDTH + 1;
    localparam int DW = 31 + 32 + FW;
    localparam logic [31:0] CONF_MAX = {{(32-FW){1'b0}}, {FW{1'b1}}};

    typedef struct packed {
        logic [31:1]          pc;
        logic [31:0]          value;
        logic [FW-1:0]        conf;
    } upd_t;

    upd_t                 entry0;
    upd_t                 entry1;
    upd_t                 head;
    logic [CW-1:0]        count;
    logic [1:0]           slot_live;
    logic [1:0]           push;
    logic [1:0]           dropped;
    logic [1:0]           n_drop;
    logic [P_DROP_W:0]    drop_sum;

`ifdef VP_FB_MERGE_EN
    assign slot_live = (fb_valid_i == 2'b11 && fb_pc_i[0] == fb_pc_i[1]) ? 2'b10 : fb_valid_i;
`else
    assign slot_live = fb_valid_i;
`endif

    always_comb begin
        entry0.pc    = fb_pc_i[0];
        entry0.value = fb_actual_i[0];
        entry0.conf  = FW'(vp_conf_next(32'(fb_conf_i[0]), fb_mispredict_i[0], CONF_MAX));
        entry1.pc    = fb_pc_i[1];
        entry1.value = fb_actual_i[1];
        entry1.conf  = FW'(vp_conf_next(32'(fb_conf_i[1]), fb_mispredict_i[1], CONF_MAX));
    end

    assign fb_ready_o = rst_ni && (count <= CW'(P_FIFO_DEPTH - 2));
    assign push       = slot_live & {2{fb_ready_o & ~flush_i}};

    vp_fb_fifo #(
        .P_WIDTH (DW),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .flush    (flush_i),
        .push     (push),
        .wr_data0 (entry0),
        .wr_data1 (entry1),
        .pop      (upd_valid_o & upd_ready_i),
        .rd_data  (head),
        .count    (count)
    );

    assign upd_valid_o = (count != '0);
    assign upd_pc_o    = head.pc;
    assign upd_value_o = head.value;
    assign upd_conf_o  = head.conf;

    // Flushed slots are discarded deliberately and so are not counted as drops.
    assign dropped  = (fb_ready_o || flush_i) ? 2'b00 : slot_live;
    assign n_drop   = {1'b0, dropped[0]} + {1'b0, dropped[1]};
    assign drop_sum = {1'b0, drop_cnt_o} + (P_DROP_W+1)'(n_drop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            drop_cnt_o <= '0;
        else if (drop_sum[P_DROP_W])
            drop_cnt_o <= '1;
        else
            drop_cnt_o <= drop_sum[P_DROP_W-1:0];
    end

endmodule

// File: tb/tb_vp_fb_scheduler.sv
// Directed self-checking bench for vp_fb_scheduler (default parameters).
module tb_vp_fb_scheduler;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [1:0][31:1] fb_pc;
    logic [1:0][31:0] fb_actual;
    logic [1:0]       fb_mis;
    logic [1:0][8:0]  fb_conf;
    logic [1:0]       fb_valid;
    logic             fb_ready;
    logic [31:1]      upd_pc;
    logic [31:0]      upd_value;
    logic [8:0]       upd_conf;
    logic             upd_valid;
    logic             upd_ready;
    logic [15:0]      drop_cnt;

    int checks = 0;
    int errors = 0;

    vp_fb_scheduler dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .fb_pc_i         (fb_pc),
        .fb_actual_i     (fb_actual),
        .fb_mispredict_i (fb_mis),
        .fb_conf_i       (fb_conf),
        .fb_valid_i      (fb_valid),
        .fb_ready_o      (fb_ready),
        .upd_pc_o        (upd_pc),
        .upd_value_o     (upd_value),
        .upd_conf_o      (upd_conf),
        .upd_valid_o     (upd_valid),
        .upd_ready_i     (upd_ready),
        .drop_cnt_o      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:1] pc0, input logic [31:1] pc1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [8:0] c0, input logic [8:0] c1, input logic [1:0] mis);
        fb_valid     = v;
        fb_pc[0]     = pc0;
        fb_pc[1]     = pc1;
        fb_actual[0] = a0;
        fb_actual[1] = a1;
        fb_conf[0]   = c0;
        fb_conf[1]   = c1;
        fb_mis       = mis;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; upd_ready = 1'b1;
        drive(2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
        tick(); tick();
        chk("ready_in_reset", 64'(fb_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_valid", 64'(upd_valid), 64'd0);
        chk("rst_pc", 64'(upd_pc), 64'd0);
        chk("rst_value", 64'(upd_value), 64'd0);
        chk("rst_conf", 64'(upd_conf), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ready", 64'(fb_ready), 64'd1);

        // pair push, drained on consecutive cycles
        drive(2'b11, 31'h080, 31'h082, 32'hA0, 32'hA1, 9'h005, 9'h005, 2'b10);
        tick();
        chk("t1_valid0", 64'(upd_valid), 64'd1);
        chk("t1_pc0", 64'(upd_pc), 64'h080);
        chk("t1_val0", 64'(upd_value), 64'hA0);
        chk("t1_conf_inc", 64'(upd_conf), 64'h006);
        chk("t1_ready0", 64'(fb_ready), 64'd1);
        drive(2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
        tick();
        chk("t1_pc1", 64'(upd_pc), 64'h082);
        chk("t1_val1", 64'(upd_value), 64'hA1);
        chk("t1_conf_mis", 64'(upd_conf), 64'h000);
        chk("t1_ready1", 64'(fb_ready), 64'd1);
        tick();
        chk("t1_empty", 64'(upd_valid), 64'd0);

        // confidence saturation and lone slot 1
        drive(2'b11, 31'h088, 31'h08A, 32'h1, 32'h2, 9'h1FF, 9'h1FE, 2'b00);
        tick();
        chk("t2_sat", 64'(upd_conf), 64'h1FF);
        drive(2'b10, '0, 31'h090, '0, 32'h3, '0, 9'h005, 2'b00);
        tick();
        chk("t2_inc_to_max", 64'(upd_conf), 64'h1FF);
        drive(2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
        tick();
        chk("t2_lone_pc", 64'(upd_pc), 64'h090);
        chk("t2_lone_conf", 64'(upd_conf), 64'h006);
        tick();
        chk("t2_empty", 64'(upd_valid), 64'd0);

        // back-pressure, drops, in-order drain
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 31'(32'h100 + 2*i), 31'(32'h101 + 2*i),
                  32'h1000 + 32'(2*i), 32'h1001 + 32'(2*i), 9'h0, 9'h0, 2'b00);
            tick();
            chk("t3_fill_ready", 64'(fb_ready), (i < 3) ? 64'd1 : 64'd0);
        end
        drive(2'b11, 31'h1FF, 31'h1FF, 32'hDEAD, 32'hBEEF, 9'h0, 9'h0, 2'b00);
        tick();
        chk("t3_drop2", 64'(drop_cnt), 64'd2);
        chk("t3_head_held", 64'(upd_pc), 64'h100);
        chk("t3_head_val", 64'(upd_value), 64'h1000);
        drive(2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
        upd_ready = 1'b1;
        tick();
        chk("t3_pc1", 64'(upd_pc), 64'h101);
        chk("t3_ready_cnt7", 64'(fb_ready), 64'd0);
        tick();
        chk("t3_pc2", 64'(upd_pc), 64'h102);
        chk("t3_ready_cnt6", 64'(fb_ready), 64'd1);
        for (int k = 3; k < 8; k++) begin
            tick();
            chk("t3_drain_pc", 64'(upd_pc), 64'(32'h100 + k));
            chk("t3_drain_val", 64'(upd_value), 64'(32'h1000 + k));
        end
        tick();
        chk("t3_empty", 64'(upd_valid), 64'd0);
        chk("t3_drop_kept", 64'(drop_cnt), 64'd2);

        // flush at count 3
        upd_ready = 1'b0;
        drive(2'b11, 31'h400, 31'h401, '0, '0, '0, '0, 2'b00);
        tick();
        drive(2'b01, 31'h402, '0, '0, '0, '0, '0, 2'b00);
        tick();
        chk("t4_head", 64'(upd_pc), 64'h400);
        flush = 1'b1; upd_ready = 1'b1;
        drive(2'b11, 31'h410, 31'h411, '0, '0, '0, '0, 2'b00);
        tick();
        chk("t4_flush_empty", 64'(upd_valid), 64'd0);
        chk("t4_flush_drop", 64'(drop_cnt), 64'd2);
        chk("t4_flush_ready", 64'(fb_ready), 64'd1);
        flush = 1'b0;
        drive(2'b01, 31'h300, '0, 32'h77, '0, '0, '0, 2'b00);
        tick();
        chk("t4_post_pc", 64'(upd_pc), 64'h300);
        chk("t4_post_val", 64'(upd_value), 64'h77);
        drive(2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
        tick();
        chk("t4_post_empty", 64'(upd_valid), 64'd0);

        // reset mid-drain at count 5, drop count 9
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 31'(32'h500 + 2*i), 31'(32'h501 + 2*i), 32'h5, 32'h6, 9'h1, 9'h1, 2'b00);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 31'h5FF, 31'h5FE, '0, '0, '0, '0, 2'b00);
            tick();
        end
        drive(2'b01, 31'h5FD, '0, '0, '0, '0, '0, 2'b00);
        tick();
        chk("t5_drop9", 64'(drop_cnt), 64'd9);
        drive(2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
        upd_ready = 1'b1;
        tick(); tick(); tick();
        chk("t5_head_cnt5", 64'(upd_pc), 64'h503);
        rst_n = 1'b0;
        tick();
        chk("t5_valid", 64'(upd_valid), 64'd0);
        chk("t5_pc", 64'(upd_pc), 64'd0);
        chk("t5_value", 64'(upd_value), 64'd0);
        chk("t5_conf", 64'(upd_conf), 64'd0);
        chk("t5_drop", 64'(drop_cnt), 64'd0);
        chk("t5_ready_low", 64'(fb_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("t5_ready_back", 64'(fb_ready), 64'd1);
        chk("t5_still_empty", 64'(upd_valid), 64'd0);

        // same-PC pair
        drive(2'b11, 31'h200, 31'h200, 32'h1, 32'h2, 9'h003, 9'h003, 2'b00);
        tick();
        drive(2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
`ifdef VP_FB_MERGE_EN
        chk("t6_merge_val", 64'(upd_value), 64'h2);
        chk("t6_merge_conf", 64'(upd_conf), 64'h4);
        tick();
        chk("t6_merge_single", 64'(upd_valid), 64'd0);
`else
        chk("t6_first_val", 64'(upd_value), 64'h1);
        chk("t6_first_conf", 64'(upd_conf), 64'h4);
        tick();
        chk("t6_second_val", 64'(upd_value), 64'h2);
        chk("t6_second_valid", 64'(upd_valid), 64'd1);
        tick();
        chk("t6_empty", 64'(upd_valid), 64'd0);
`endif
        chk("t6_no_drop", 64'(drop_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
